i2c_reg16_wr_engine: RTL and testbench

I2C write-transaction engine for the MIPI bridge configuration path. Sits directly downstream of the bridge configuration sequencer: the sequencer presents slave address, 16-bit register pointer and 16-bit data, then pulses GO. This block serialises the transfer onto open-drain SCL/SDA with start, per-byte ACK check and stop, and reports completion on END_OK. The same engine handles pointer-only writes (BYTE_NUM=2) and full register writes (BYTE_NUM=4).

---
 rtl/i2c_pkg.sv | 37 +++
 rtl/i2c_wr_byte_shift.sv | 59 +++++
 rtl/i2c_reg16_wr_engine.sv | 171 +++++++++++++++++
 tb/tb_i2c_reg16_wr_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register write engine: state encoding,
// bit-phase codes, transfer limits and the outgoing byte selector.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [2:0] BYTE_NUM_MAX = 3'd4;
  localparam logic [1:0] START_CYC    = 2'd2;
  localparam logic [1:0] STOP_CYC     = 2'd3;

  // Wire order: address, pointer MSB, pointer LSB, data MSB, data LSB.
  function automatic logic [7:0] byte_at(input logic [7:0]  addr,
                                         input logic [15:0] ptr,
                                         input logic [15:0] wdata,
                                         input logic [2:0]  idx);
    case (idx)
      3'd0:    byte_at = addr;
      3'd1:    byte_at = ptr[15:8];
      3'd2:    byte_at = ptr[7:0];
      3'd3:    byte_at = wdata[15:8];
      default: byte_at = wdata[7:0];
    endcase
  endfunction

endpackage

// File: rtl/i2c_wr_byte_shift.sv
// One byte plus ACK slot on the bus: 8 data bits MSB first, then a released
// SDA bit whose q3 sample of SDAI decides ACK (0) or NACK (1).
module i2c_wr_byte_shift
  import i2c_pkg::*;
(
  input  logic       PT_CK,
  input  logic       RESET_N,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       sdai,
  output logic       sclo,
  output logic       sdao,
  output logic       last_bit,
  output logic       byte_done,
  output logic       nack
);

  logic [7:0] sr;
  logic [3:0] bitn;
  logic [1:0] q;
  logic       busy;

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      sr   <= '1;
      bitn <= '0;
      q    <= Q0;
      busy <= 1'b0;
    end else if (load) begin
      sr   <= din;
      bitn <= '0;
      q    <= Q0;
      busy <= 1'b1;
    end else if (busy) begin
      case (q)
        Q0:      q <= Q1;
        Q1:      q <= Q2;
        Q2:      q <= Q3;
        default: q <= Q0;
      endcase
      if (q == Q3) begin
        if (bitn == 4'd8) begin
          busy <= 1'b0;
        end else begin
          bitn <= bitn + 4'd1;
          sr   <= {sr[6:0], 1'b1};
        end
      end
    end
  end

  // bitn==8 is the ACK slot, where SDA is released.
  assign sclo      = busy ? (q == Q2 || q == Q3) : 1'b1;
  assign sdao      = busy ? (bitn[3] | sr[7]) : 1'b1;
  assign last_bit  = busy && bitn == 4'd7 && q == Q3;
  assign byte_done = busy && bitn == 4'd8 && q == Q3;
  assign nack      = byte_done && sdai;

endmodule

// File: rtl/i2c_reg16_wr_engine.sv
// I2C write engine: START, address + up to 4 payload bytes with ACK check, STOP.
// Optional I2C_WR_NACK_RETRY_EN re-runs the transfer after a NACK, RETRY_MAX times.
module i2c_reg16_wr_engine
  import i2c_pkg::*;
#(
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic        PT_CK,
  input  logic        RESET_N,
  input  logic        GO,
  input  logic [7:0]  SLAVE_ADDRESS,
  input  logic [15:0] POINTER,
  input  logic [15:0] WDATA,
  input  logic [2:0]  BYTE_NUM,
  input  logic        SDAI,
  output logic        SDAO,
  output logic        SCLO,
  output logic        END_OK,
  output logic        ACK_OK,
  output logic [7:0]  ST
);

  if (RETRY_MAX > 255) begin : g_retry_range
    $error("RETRY_MAX must fit in 8 bits");
  end

  i2c_state_e  st;
  logic        go_q, pending;
  logic [1:0]  cnt;
  logic [2:0]  byte_idx, last_idx;
  logic [7:0]  addr_l;
  logic [15:0] ptr_l, wdata_l;
  logic        nack_seen, sclo_r, sdao_r;
  logic        bs_load, bs_sclo, bs_sdao, bs_last_bit, bs_byte_done, bs_nack;
  logic [7:0]  bs_din;
`ifdef I2C_WR_NACK_RETRY_EN
  logic [7:0]  retry_cnt;
`endif

  always_comb begin
    bs_load = 1'b0;
    bs_din  = byte_at(addr_l, ptr_l, wdata_l, 3'd0);
    if (st == START && cnt == START_CYC - 2'd1) begin
      bs_load = 1'b1;
    end else if (st == ACK && bs_byte_done && !bs_nack && byte_idx != last_idx) begin
      bs_load = 1'b1;
      bs_din  = byte_at(addr_l, ptr_l, wdata_l, byte_idx + 3'd1);
    end
  end

  i2c_wr_byte_shift u_shift (
    .PT_CK     (PT_CK),
    .RESET_N   (RESET_N),
    .load      (bs_load),
    .din       (bs_din),
    .sdai      (SDAI),
    .sclo      (bs_sclo),
    .sdao      (bs_sdao),
    .last_bit  (bs_last_bit),
    .byte_done (bs_byte_done),
    .nack      (bs_nack)
  );

  // The GO rise is latched one cycle ahead of START so END_OK drops on cycle 1.
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      st        <= IDLE;
      go_q      <= 1'b1;
      pending   <= 1'b0;
      cnt       <= '0;
      byte_idx  <= '0;
      last_idx  <= '0;
      addr_l    <= '0;
      ptr_l     <= '0;
      wdata_l   <= '0;
      nack_seen <= 1'b0;
      sclo_r    <= 1'b1;
      sdao_r    <= 1'b1;
      END_OK    <= 1'b1;
      ACK_OK    <= 1'b0;
`ifdef I2C_WR_NACK_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      go_q <= GO;
      case (st)
        IDLE: begin
          sclo_r <= 1'b1;
          sdao_r <= 1'b1;
          if (pending) begin
            pending   <= 1'b0;
            st        <= START;
            cnt       <= '0;
            byte_idx  <= '0;
            nack_seen <= 1'b0;
            END_OK    <= 1'b0;
            sdao_r    <= 1'b0;
`ifdef I2C_WR_NACK_RETRY_EN
            retry_cnt <= '0;
`endif
          end else if (GO && !go_q) begin
            pending  <= 1'b1;
            addr_l   <= SLAVE_ADDRESS;
            ptr_l    <= POINTER;
            wdata_l  <= WDATA;
            last_idx <= (BYTE_NUM > BYTE_NUM_MAX) ? BYTE_NUM_MAX : BYTE_NUM;
          end
        end
        START: begin
          if (cnt == START_CYC - 2'd1) begin
            st  <= BIT;
            cnt <= '0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        BIT: begin
          if (bs_last_bit) st <= ACK;
        end
        ACK: begin
          if (bs_byte_done) begin
            if (bs_nack || byte_idx == last_idx) begin
              st     <= STOP;
              cnt    <= '0;
              sclo_r <= 1'b0;
              sdao_r <= 1'b0;
              if (bs_nack) nack_seen <= 1'b1;
            end else begin
              st       <= BIT;
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        STOP: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd0) begin
            sclo_r <= 1'b1;
          end else if (cnt == 2'd1) begin
            sdao_r <= 1'b1;
          end else if (cnt == STOP_CYC - 2'd1) begin
`ifdef I2C_WR_NACK_RETRY_EN
            if (nack_seen && 32'(retry_cnt) < RETRY_MAX) begin
              st        <= START;
              cnt       <= '0;
              byte_idx  <= '0;
              nack_seen <= 1'b0;
              sdao_r    <= 1'b0;
              retry_cnt <= retry_cnt + 8'd1;
            end else begin
              st     <= DONE;
              END_OK <= 1'b1;
              ACK_OK <= !nack_seen;
            end
`else
            st     <= DONE;
            END_OK <= 1'b1;
            ACK_OK <= !nack_seen;
`endif
          end
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign SCLO = (st == BIT || st == ACK) ? bs_sclo : sclo_r;
  assign SDAO = (st == BIT || st == ACK) ? bs_sdao : sdao_r;
  assign ST   = {5'd0, st};

endmodule

// File: tb/tb_i2c_reg16_wr_engine.sv
// Bench for i2c_reg16_wr_engine: bus-level slave model decodes the bytes and
// injects NACKs; expected bytes, timing and status come from transfer rules.
module tb_i2c_reg16_wr_engine;

  localparam int unsigned RETRY = 3;

  logic        PT_CK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        GO = 1'b1;
  logic [7:0]  SLAVE_ADDRESS = '0;
  logic [15:0] POINTER = '0;
  logic [15:0] WDATA = '0;
  logic [2:0]  BYTE_NUM = '0;
  logic        SDAI, SDAO, SCLO, END_OK, ACK_OK;
  logic [7:0]  ST;

  logic        s_sda = 1'b1;
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_starts = 0;
  int          nack_idx = -1;
  int          nack_left = 0;
  logic [7:0]  got[$];

  assign SDAI = SDAO & s_sda;

  i2c_reg16_wr_engine #(.RETRY_MAX(RETRY)) dut (
    .PT_CK         (PT_CK),
    .RESET_N       (RESET_N),
    .GO            (GO),
    .SLAVE_ADDRESS (SLAVE_ADDRESS),
    .POINTER       (POINTER),
    .WDATA         (WDATA),
    .BYTE_NUM      (BYTE_NUM),
    .SDAI          (SDAI),
    .SDAO          (SDAO),
    .SCLO          (SCLO),
    .END_OK        (END_OK),
    .ACK_OK        (ACK_OK),
    .ST            (ST)
  );

  always #5 PT_CK = ~PT_CK;

  // Slave: decodes START and data bits on SCL rise, drives ACK/NACK per byte.
  initial begin
    logic       pscl, psda, sda;
    logic [7:0] shr;
    int         bitcnt, fbyte;
    bit         acking;
    pscl = 1'b1; psda = 1'b1; shr = '0; bitcnt = 0; fbyte = 0; acking = 1'b0;
    forever begin
      @(negedge PT_CK or negedge RESET_N);
      if (!RESET_N) begin
        s_sda = 1'b1; bitcnt = 0; fbyte = 0; acking = 1'b0; pscl = 1'b1; psda = 1'b1;
      end else begin
        sda = SDAO & s_sda;
        if (pscl && SCLO && psda && !sda) begin
          n_starts++; bitcnt = 0; fbyte = 0; acking = 1'b0;
        end else if (!pscl && SCLO) begin
          if (bitcnt < 8) begin
            shr = {shr[6:0], sda};
            bitcnt++;
            if (bitcnt == 8) begin
              got.push_back(shr);
              fbyte++;
            end
          end
        end else if (pscl && !SCLO) begin
          if (acking) begin
            acking = 1'b0; s_sda = 1'b1; bitcnt = 0;
          end else if (bitcnt == 8) begin
            acking = 1'b1;
            if (fbyte - 1 == nack_idx && nack_left > 0) begin
              nack_left--; s_sda = 1'b1;
            end else begin
              s_sda = 1'b0;
            end
          end
        end
        pscl = SCLO;
        psda = SDAO & s_sda;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [15:0] p, input logic [15:0] w,
                         input logic [2:0] bn, input int nk, input int ntimes, input bit disturb);
    logic [7:0] all5 [5];
    logic [7:0] expq[$];
    int n, fails, attempts, m, exp_cyc, end_cyc, cyc;
    bit exp_ack;
    n = (bn > 3'd4) ? 4 : int'(bn);
    all5 = '{a, p[15:8], p[7:0], w[15:8], w[7:0]};
    fails = 0;
    if (nk >= 0 && nk <= n && ntimes > 0) begin
`ifdef I2C_WR_NACK_RETRY_EN
      fails = (ntimes > int'(RETRY) + 1) ? int'(RETRY) + 1 : ntimes;
`else
      fails = 1;
`endif
    end
`ifdef I2C_WR_NACK_RETRY_EN
    attempts = (fails == int'(RETRY) + 1) ? fails : fails + 1;
`else
    attempts = 1;
`endif
    exp_ack = (attempts > fails);
    exp_cyc = 1;
    for (int at = 0; at < attempts; at++) begin
      m = (at < fails) ? nk + 1 : n + 1;
      exp_cyc += 5 + 36 * m;
      for (int i = 0; i < m; i++) expq.push_back(all5[i]);
    end

    GO = 1'b0;
    repeat (2) @(posedge PT_CK);
    #1;
    got.delete(); n_starts = 0; nack_idx = nk; nack_left = ntimes;
    SLAVE_ADDRESS = a; POINTER = p; WDATA = w; BYTE_NUM = bn; GO = 1'b1;
    end_cyc = -1;
    for (cyc = 0; cyc < 3000 && end_cyc < 0; cyc++) begin
      @(posedge PT_CK);
      #1;
      if (cyc == 0) chk("end_ok_cycle0", 32'(END_OK), 32'd1);
      if (cyc == 1) chk("end_ok_cycle1", 32'(END_OK), 32'd0);
      if (disturb && cyc == 10) WDATA = ~w;
      if (disturb && cyc == 30) GO = 1'b0;
      if (disturb && cyc == 49) GO = 1'b1;
      if (cyc >= 1 && END_OK) end_cyc = cyc;
    end
    chk("end_cycle", 32'(end_cyc), 32'(exp_cyc));
    chk("ack_ok", 32'(ACK_OK), 32'(exp_ack));
    chk("byte_count", 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got[i]), 32'(expq[i]));
    chk("start_count", 32'(n_starts), 32'(attempts));
    repeat (3) @(posedge PT_CK);
    #1;
    chk("idle_after", {22'd0, ST, SCLO, SDAO}, {22'd0, 8'd0, 2'b11});
  endtask

  initial begin
    repeat (3) @(posedge PT_CK);
    #1;
    chk("rst_outputs", {28'd0, SCLO, SDAO, END_OK, ACK_OK}, 32'b1110);
    chk("rst_st", 32'(ST), 32'd0);
    @(negedge PT_CK) RESET_N = 1'b1;
    repeat (20) @(posedge PT_CK);
    #1;
    chk("go_high_at_reset", 32'(n_starts), 32'd0);
    chk("idle_outputs", {29'd0, SCLO, SDAO, END_OK}, 32'b111);

    run_txn(8'h1C, 16'h0002, 16'h0001, 3'd4, -1, 0, 1'b0);
    run_txn(8'h1C, 16'h0000, 16'h0001, 3'd2, -1, 0, 1'b0);
    run_txn(8'h1C, 16'h0002, 16'h0001, 3'd4, 0, 2, 1'b0);
    run_txn(8'h1C, 16'h0002, 16'h0001, 3'd0, -1, 0, 1'b0);
    run_txn(8'h1C, 16'h1234, 16'hABCD, 3'd4, -1, 0, 1'b1);
    run_txn(8'h3A, 16'h5A5A, 16'hC3C3, 3'd7, -1, 0, 1'b0);
    run_txn(8'h1C, 16'h00FF, 16'hFF00, 3'd4, 2, 1, 1'b0);

    // Reset in the middle of byte 2.
    GO = 1'b0;
    repeat (2) @(posedge PT_CK);
    #1;
    n_starts = 0; nack_idx = -1; nack_left = 0;
    SLAVE_ADDRESS = 8'h1C; POINTER = 16'h0002; WDATA = 16'h0001; BYTE_NUM = 3'd4; GO = 1'b1;
    repeat (81) @(posedge PT_CK);
    #1;
    chk("busy_before_reset", 32'(END_OK), 32'd0);
    RESET_N = 1'b0;
    #1;
    chk("async_reset_bus", {29'd0, SCLO, SDAO, END_OK}, 32'b111);
    @(negedge PT_CK) RESET_N = 1'b1;
    repeat (10) @(posedge PT_CK);
    #1;
    chk("no_restart_after_reset", 32'(n_starts), 32'd1);
    run_txn(8'h1C, 16'h0002, 16'h0001, 3'd4, -1, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int nk;
      nk = int'($urandom_range(0, 5));
      if (nk == 5) nk = -1;
      run_txn(8'($urandom), 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
              nk, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
